// File: rtl/fifo_in_sync_tuser_if.sv
// Ingress FIFO bundle: AXI-Stream slave beats in, FWFT head and status out.
// slave: FIFO side (takes S_AXIS_*, IN_RDEN); master: producer/consumer side.
interface fifo_in_sync_tuser_if #(
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int DEPTH      = 16
);
  localparam int KW = DATA_WIDTH / 8;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] S_AXIS_TDATA;
  logic [KW-1:0]         S_AXIS_TKEEP;
  logic [USER_WIDTH-1:0] S_AXIS_TUSER;
  logic                  S_AXIS_TLAST;
  logic                  S_AXIS_TVALID;
  logic                  S_AXIS_TREADY;
  logic [DATA_WIDTH-1:0] IN_DOUT_DATA;
  logic [KW-1:0]         IN_DOUT_KEEP;
  logic [USER_WIDTH-1:0] IN_DOUT_USER;
  logic                  IN_DOUT_LAST;
  logic                  IN_RDEN;
  logic                  IN_EMPTY;
  logic                  IN_AEMPTY;
  logic [CW-1:0]         IN_COUNT;
  logic                  IN_UNDERFLOW;

  modport slave (
    input  S_AXIS_TDATA, S_AXIS_TKEEP, S_AXIS_TUSER,
    input  S_AXIS_TLAST, S_AXIS_TVALID, IN_RDEN,
    output S_AXIS_TREADY,
    output IN_DOUT_DATA, IN_DOUT_KEEP, IN_DOUT_USER,
    output IN_DOUT_LAST, IN_EMPTY, IN_AEMPTY,
    output IN_COUNT, IN_UNDERFLOW
  );

  modport master (
    output S_AXIS_TDATA, S_AXIS_TKEEP, S_AXIS_TUSER,
    output S_AXIS_TLAST, S_AXIS_TVALID, IN_RDEN,
    input  S_AXIS_TREADY,
    input  IN_DOUT_DATA, IN_DOUT_KEEP, IN_DOUT_USER,
    input  IN_DOUT_LAST, IN_EMPTY, IN_AEMPTY,
    input  IN_COUNT, IN_UNDERFLOW
  );
endinterface

// File: rtl/fifo_in_sync_tuser.sv
// Ingress sync FIFO: AXI-Stream beats in, first-word-fall-through head out.
// Ports: CLK, RESET (async high), bus (slave modport: S_AXIS_*, IN_*).
module fifo_in_sync_tuser #(
  parameter int DATA_WIDTH    = 8,
  parameter int USER_WIDTH    = 1,
  parameter int DEPTH         = 16,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  fifo_in_sync_tuser_if.slave   bus
);
  localparam int KW = DATA_WIDTH / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = DATA_WIDTH + KW + USER_WIDTH + 1;
  localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
  localparam logic [PW-1:0] AE_CNT   = PW'(AEMPTY_THRESH);
  localparam logic [PW-1:0] ONE      = PW'(1);

  logic [EW-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          empty_q, empty_d;
  logic          aempty_q, aempty_d;
  logic          tready_q, tready_d;
  logic          uflow_q, uflow_d;
  logic          wr, rd;
  logic [EW-1:0] head;

  always_comb begin
    wr       = bus.S_AXIS_TVALID & tready_q;
    rd       = bus.IN_RDEN & ~empty_q;
    wr_ptr_d = wr ? wr_ptr_q + ONE : wr_ptr_q;
    rd_ptr_d = rd ? rd_ptr_q + ONE : rd_ptr_q;
    count_d  = count_q;
    case ({wr, rd})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
    // Flags come from the next count so they are plain flops,
    // keeping IN_RDEN off any combinational path to TREADY.
    empty_d  = (count_d == '0);
    aempty_d = (count_d <= AE_CNT);
    tready_d = (count_d != FULL_CNT);
    uflow_d  = bus.IN_RDEN & empty_q;
  end

  // Storage carries no reset; stale entries are hidden by IN_EMPTY.
  always_ff @(posedge CLK) begin
    if (wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {bus.S_AXIS_TLAST, bus.S_AXIS_TUSER,
                                  bus.S_AXIS_TKEEP, bus.S_AXIS_TDATA};
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      tready_q <= 1'b0;
      uflow_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
      tready_q <= tready_d;
      uflow_q  <= uflow_d;
    end
  end

  assign head = mem_q[rd_ptr_q[AW-1:0]];

  assign {bus.IN_DOUT_LAST, bus.IN_DOUT_USER,
          bus.IN_DOUT_KEEP, bus.IN_DOUT_DATA} = head;

  assign bus.S_AXIS_TREADY = tready_q;
  assign bus.IN_EMPTY      = empty_q;
  assign bus.IN_AEMPTY     = aempty_q;
  assign bus.IN_COUNT      = count_q;
  assign bus.IN_UNDERFLOW  = uflow_q;
endmodule
